// File: rtl/part_74ls109_sync.sv
// Cycle-based 74LS109 dual J-K_N flip-flop with preset/clear; pin clocks are sampled on clk.
// Section 2 is built only when LS109_SECTION2_EN is defined, otherwise its outputs are constants.
module part_74ls109_sync #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic CLR1_N,
  input  logic PRE1_N,
  input  logic J1,
  input  logic K1_N,
  input  logic CLK1,
  output logic Q1,
  output logic Q1_N,
  input  logic CLR2_N,
  input  logic PRE2_N,
  input  logic J2,
  input  logic K2_N,
  input  logic CLK2,
  output logic Q2,
  output logic Q2_N
);

`ifdef LS109_SECTION2_EN
  localparam int NUM_SEC = 2;
`else
  localparam int NUM_SEC = 1;
`endif

  logic [NUM_SEC-1:0] clr_n, pre_n, j, k_n, pin_clk, q, q_n;

`ifdef LS109_SECTION2_EN
  assign clr_n   = {CLR2_N, CLR1_N};
  assign pre_n   = {PRE2_N, PRE1_N};
  assign j       = {J2, J1};
  assign k_n     = {K2_N, K1_N};
  assign pin_clk = {CLK2, CLK1};
  assign Q2      = q[1];
  assign Q2_N    = q_n[1];
`else
  assign clr_n   = CLR1_N;
  assign pre_n   = PRE1_N;
  assign j       = J1;
  assign k_n     = K1_N;
  assign pin_clk = CLK1;
  assign Q2      = RESET_Q;
  assign Q2_N    = ~RESET_Q;
  logic unused_sec2;
  assign unused_sec2 = ^{CLR2_N, PRE2_N, J2, K2_N, CLK2};
`endif

  assign Q1   = q[0];
  assign Q1_N = q_n[0];

  for (genvar gi = 0; gi < NUM_SEC; gi++) begin : g_sec
    logic q_reg, q_next, qn_reg, qn_next, prev_reg;
    logic pin_edge;

    assign pin_edge = ~prev_reg & pin_clk[gi];

    always_comb begin
      q_next  = q_reg;
      qn_next = qn_reg;
      if (!clr_n[gi] && !pre_n[gi]) begin
        q_next  = 1'b1;
        qn_next = 1'b1;
      end else if (!clr_n[gi]) begin
        q_next  = 1'b0;
        qn_next = 1'b1;
      end else if (!pre_n[gi]) begin
        q_next  = 1'b1;
        qn_next = 1'b0;
      end else if (pin_edge) begin
        case ({j[gi], k_n[gi]})
          2'b00: begin
            q_next  = 1'b0;
            qn_next = 1'b1;
          end
          // Toggle uses the true output only, so the both-high state resolves to 0/1.
          2'b10: begin
            q_next  = ~q_reg;
            qn_next = q_reg;
          end
          2'b11: begin
            q_next  = 1'b1;
            qn_next = 1'b0;
          end
          default: ;
        endcase
      end
    end

    // prev starts high so a pin clock already high at reset release is not an edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_reg    <= RESET_Q;
        qn_reg   <= ~RESET_Q;
        prev_reg <= 1'b1;
      end else begin
        q_reg    <= q_next;
        qn_reg   <= qn_next;
        prev_reg <= pin_clk[gi];
      end
    end

    assign q[gi]   = q_reg;
    assign q_n[gi] = qn_reg;
  end

endmodule

// File: tb/tb_part_74ls109_sync.sv
// Bench for part_74ls109_sync: directed vector table, a pulse-train sequence, and random
// stimulus on both sections compared against a J-K characteristic-equation model.
module tb_part_74ls109_sync;

`ifdef LS109_SECTION2_EN
  localparam bit SEC2 = 1'b1;
`else
  localparam bit SEC2 = 1'b0;
`endif
  localparam logic RQ = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic CLR1_N = 1'b1, PRE1_N = 1'b1, J1 = 1'b0, K1_N = 1'b1, CLK1 = 1'b0;
  logic CLR2_N = 1'b1, PRE2_N = 1'b1, J2 = 1'b0, K2_N = 1'b1, CLK2 = 1'b0;
  logic Q1, Q1_N, Q2, Q2_N;

  always #5 clk = ~clk;

  part_74ls109_sync #(.RESET_Q(RQ)) dut (
    .clk(clk), .reset(reset),
    .CLR1_N(CLR1_N), .PRE1_N(PRE1_N), .J1(J1), .K1_N(K1_N), .CLK1(CLK1),
    .Q1(Q1), .Q1_N(Q1_N),
    .CLR2_N(CLR2_N), .PRE2_N(PRE2_N), .J2(J2), .K2_N(K2_N), .CLK2(CLK2),
    .Q2(Q2), .Q2_N(Q2_N)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic rst, clr_n, pre_n, j, kn, ck, q, qn;
  } vec_t;

  function automatic vec_t mk(input logic rst, clr_n, pre_n, j, kn, ck, q, qn);
    vec_t v;
    v.rst = rst; v.clr_n = clr_n; v.pre_n = pre_n; v.j = j;
    v.kn = kn; v.ck = ck; v.q = q; v.qn = qn;
    return v;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic mq[2], mqn[2], mprev[2];

  task automatic model_clk(input logic rst, input logic [1:0] clr_n, pre_n, jj, kn, ck);
    for (int s = 0; s < 2; s++) begin
      logic pin_edge;
      pin_edge = !mprev[s] && ck[s];
      if (rst || (s == 1 && !SEC2)) begin
        mq[s] = RQ; mqn[s] = !RQ; mprev[s] = 1'b1;
      end else begin
        mprev[s] = ck[s];
        if (!clr_n[s] || !pre_n[s]) begin
          mq[s]  = !pre_n[s];
          mqn[s] = !clr_n[s];
        end else if (pin_edge && !(jj[s] == 1'b0 && kn[s] == 1'b1)) begin
          // Characteristic equation of a J-K_N flip-flop: Q+ = J&~Q | K_N&Q
          mq[s]  = (jj[s] & !mq[s]) | (kn[s] & mq[s]);
          mqn[s] = !mq[s];
        end
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic exp_q;
    logic [1:0] r_clr, r_pre, r_j, r_kn, r_ck;
    logic r_rst;

    //                  rst clr pre j kn ck  q qn
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1));  // reset with CLK1 high
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1));  // release: no edge
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0));  // preset
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));  // clear
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1));  // both -> both high
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1));  // release, holds both high
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1));  // toggle from both high
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1, 0));  // toggle
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1));  // toggle
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1));  // hold at 0
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0));  // set
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0));  // hold at 1
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));  // reset via J/K
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));  // clear asserted
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1));  // edge under clear consumed
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1));  // not replayed
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0));  // set
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 1));  // reset mid-operation
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1));  // no edge first clk after reset
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; CLR1_N = tbl[i].clr_n; PRE1_N = tbl[i].pre_n;
      J1 = tbl[i].j; K1_N = tbl[i].kn; CLK1 = tbl[i].ck;
      tick();
      $display("vec %0d: rst=%b clr_n=%b pre_n=%b j=%b kn=%b ck=%b -> q1=%b q1n=%b q2=%b q2n=%b",
               i, tbl[i].rst, tbl[i].clr_n, tbl[i].pre_n, tbl[i].j, tbl[i].kn, tbl[i].ck,
               Q1, Q1_N, Q2, Q2_N);
      check($sformatf("vec%0d_q1", i), Q1, tbl[i].q);
      check($sformatf("vec%0d_q1n", i), Q1_N, tbl[i].qn);
      check($sformatf("vec%0d_q2", i), Q2, RQ);
      check($sformatf("vec%0d_q2n", i), Q2_N, !RQ);
    end

    // Pin clock toggling every clk: shortest legal pulse, toggles on each rising edge
    exp_q = 1'b1;
    J1 = 1'b1; K1_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      CLK1 = i[0];
      if (i[0]) exp_q = !exp_q;
      tick();
      $display("pulse %0d: ck=%b -> q1=%b q1n=%b", i, CLK1, Q1, Q1_N);
      check($sformatf("pulse%0d_q1", i), Q1, exp_q);
      check($sformatf("pulse%0d_q1n", i), Q1_N, !exp_q);
    end

    // Random stimulus on both sections against the model
    for (int i = 0; i < 300; i++) begin
      r_rst = (i == 0) || ($urandom_range(39) == 0);
      for (int s = 0; s < 2; s++) begin
        r_clr[s] = ($urandom_range(7) != 0);
        r_pre[s] = ($urandom_range(7) != 0);
        r_j[s]   = 1'($urandom_range(1));
        r_kn[s]  = 1'($urandom_range(1));
        r_ck[s]  = 1'($urandom_range(1));
      end
      reset = r_rst;
      CLR1_N = r_clr[0]; PRE1_N = r_pre[0]; J1 = r_j[0]; K1_N = r_kn[0]; CLK1 = r_ck[0];
      CLR2_N = r_clr[1]; PRE2_N = r_pre[1]; J2 = r_j[1]; K2_N = r_kn[1]; CLK2 = r_ck[1];
      tick();
      model_clk(r_rst, r_clr, r_pre, r_j, r_kn, r_ck);
      $display("rand %0d: rst=%b s1=%b%b%b%b%b s2=%b%b%b%b%b -> %b%b %b%b (model %b%b %b%b)",
               i, r_rst, r_clr[0], r_pre[0], r_j[0], r_kn[0], r_ck[0],
               r_clr[1], r_pre[1], r_j[1], r_kn[1], r_ck[1],
               Q1, Q1_N, Q2, Q2_N, mq[0], mqn[0], mq[1], mqn[1]);
      check($sformatf("rand%0d_q1", i), Q1, mq[0]);
      check($sformatf("rand%0d_q1n", i), Q1_N, mqn[0]);
      check($sformatf("rand%0d_q2", i), Q2, mq[1]);
      check($sformatf("rand%0d_q2n", i), Q2_N, mqn[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
